// File: rtl/two_phase_pkg.sv
// Shared types and helpers for the two-phase channel arbiter.
package two_phase_pkg;

  // Arbiter FSM encoding
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    DONE     = 2'd2
  } state_e;

  localparam int unsigned DEF_SYNC_STAGES = 2;

  // Ceiling log2 for elaboration-time widths; clog2(1) == 0
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((33'd1 << i) < 33'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/two_phase_channel_arbiter_if.sv
// Requester-side and channel-side signals of the two-phase arbiter.
interface two_phase_channel_arbiter_if
  import two_phase_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = 8
);
  localparam int unsigned ID_W = clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] data_in;
  logic [NUM_REQ-1:0]        ack;
  logic                      out_req;
  logic                      out_ack;
  logic [DATA_W-1:0]         data_out;
  logic [ID_W-1:0]           grant_id;
  logic                      busy;
  logic                      timeout_err;

  // Environment side: requesters plus the downstream channel
  modport master (
    output req, data_in, out_ack,
    input  ack, out_req, data_out, grant_id, busy, timeout_err
  );

  // Arbiter side
  modport slave (
    input  req, data_in, out_ack,
    output ack, out_req, data_out, grant_id, busy, timeout_err
  );
endinterface

// File: rtl/two_phase_sync.sv
// Single-bit multi-flop synchroniser for an asynchronous two-phase wire.
module two_phase_sync
  import two_phase_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // Shift the raw input one stage per clock
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  // Synchroniser flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/two_phase_channel_arbiter.sv
// Round-robin arbiter merging NUM_REQ two-phase requesters onto one
// two-phase downstream channel, with a sticky stall watchdog.
module two_phase_channel_arbiter
  import two_phase_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  two_phase_channel_arbiter_if.slave   bus
);
  localparam int unsigned ID_W  = clog2(NUM_REQ);
  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : clog2(TIMEOUT + 1);
  // With the watchdog disabled the counter just saturates at 1
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'((TIMEOUT == 0) ? 1 : TIMEOUT);
  localparam bit WD_EN = (TIMEOUT != 0);

  logic [NUM_REQ-1:0] req_s;
  logic               out_ack_s;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               out_req_q, out_req_d;
  logic [DATA_W-1:0]  data_out_q, data_out_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [ID_W-1:0]    last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               timeout_err_q, timeout_err_d;

  logic [NUM_REQ-1:0] pending;
  logic [ID_W:0]      pick;
  logic               pick_valid;
  logic [ID_W-1:0]    pick_idx;
  logic [DATA_W-1:0]  words [NUM_REQ];

  // One synchroniser per request wire and one for the channel ack
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req_sync
    two_phase_sync #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.req[i]),
      .q   (req_s[i])
    );
  end

  two_phase_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.out_ack),
    .q   (out_ack_s)
  );

  // Split the flat data bus into per-requester words
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
    assign words[i] = bus.data_in[i*DATA_W +: DATA_W];
  end

  // First pending index after last, wrapping; MSB of result is 'found'
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] pend,
                                            input logic [ID_W-1:0]    last);
    logic [ID_W:0] res;
    int unsigned   idx;
    res = '0;
    // Walk from farthest to nearest so the nearest hit is kept
    for (int k = NUM_REQ; k > 0; k--) begin
      idx = (32'(last) + 32'(k)) % NUM_REQ;
      if (pend[ID_W'(idx)]) res = {1'b1, ID_W'(idx)};
    end
    return res;
  endfunction

  // Pending requests and the round-robin winner
  always_comb begin
    pending    = req_s ^ ack_q;
    pick       = rr_pick(pending, last_grant_q);
    pick_valid = pick[ID_W];
    pick_idx   = pick[ID_W-1:0];
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    ack_d         = ack_q;
    out_req_d     = out_req_q;
    data_out_d    = data_out_q;
    grant_id_d    = grant_id_q;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          out_req_d  = ~out_req_q;
          grant_id_d = pick_idx;
          data_out_d = words[pick_idx];
          cnt_d      = '0;
          state_d    = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (out_ack_s == out_req_q) begin
          state_d = DONE;
        end else begin
          // Keep waiting forever; only raise the sticky flag
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
          if (WD_EN && (cnt_d == CNT_SAT)) timeout_err_d = 1'b1;
        end
      end
      DONE: begin
        ack_d[grant_id_q] = ~ack_q[grant_id_q];
        last_grant_d      = grant_id_q;
        state_d           = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ack_q         <= '0;
      out_req_q     <= 1'b0;
      data_out_q    <= '0;
      grant_id_q    <= '0;
      last_grant_q  <= ID_W'(NUM_REQ - 1);
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ack_q         <= ack_d;
      out_req_q     <= out_req_d;
      data_out_q    <= data_out_d;
      grant_id_q    <= grant_id_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.ack         = ack_q;
  assign bus.out_req     = out_req_q;
  assign bus.data_out    = data_out_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_two_phase_channel_arbiter.sv
// Directed bench for two_phase_channel_arbiter with a transaction-level
// reference model compared every falling edge.
module tb_two_phase_channel_arbiter;
  import two_phase_pkg::*;

  localparam int unsigned NR  = 2;
  localparam int unsigned DW  = 8;
  localparam int unsigned SS  = 2;
  localparam int unsigned TO  = 16;
  localparam int          NRI = NR;
  localparam int          TOI = TO;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   clk_en = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  two_phase_channel_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  two_phase_channel_arbiter #(
    .NUM_REQ(NR), .DATA_W(DW), .SYNC_STAGES(SS), .TIMEOUT(TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock that can be parked low
  always begin
    #5;
    if (clk_en) clk = ~clk;
    else        clk = 1'b0;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_ack(input logic [NR-1:0] exp, input int maxc, input string name);
    int c;
    c = 0;
    while (bus.ack !== exp && c < maxc) begin
      tick(1);
      c++;
    end
    vectors++;
    if (bus.ack !== exp) begin
      miscompares++;
      $display("FAIL %s: ack=%b after %0d cycles, expected %b", name, bus.ack, c, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Inputs become visible SS clocks late; a transfer is: claim in idle,
  // wait for the echoed ack, then one finishing cycle that returns the ack.
  logic [NR-1:0] rq_line [SS];
  logic          oa_line [SS];
  logic [NR-1:0] m_ack;
  logic          m_oreq;
  logic [DW-1:0] m_data;
  int            m_gid, m_last, m_phase, m_wait;
  logic          m_busy, m_err;

  always @(posedge clk or posedge rst) begin : model
    logic [NR-1:0] pend;
    logic          oas;
    int            best, bestd, d;
    if (rst) begin
      for (int k = 0; k < SS; k++) begin
        rq_line[k] <= '0;
        oa_line[k] <= 1'b0;
      end
      m_ack <= '0; m_oreq <= 1'b0; m_data <= '0; m_gid <= 0;
      m_last <= NRI - 1; m_phase <= 0; m_wait <= 0; m_busy <= 1'b0; m_err <= 1'b0;
    end else begin
      pend = rq_line[SS-1] ^ m_ack;
      oas  = oa_line[SS-1];
      if (m_phase == 0) begin
        best  = -1;
        bestd = NRI;
        for (int i = 0; i < NRI; i++) begin
          if (pend[i]) begin
            d = (i - m_last - 1 + 2 * NRI) % NRI;
            if (d < bestd) begin bestd = d; best = i; end
          end
        end
        if (best >= 0) begin
          m_gid   <= best;
          m_data  <= bus.data_in[best*DW +: DW];
          m_oreq  <= ~m_oreq;
          m_wait  <= 0;
          m_phase <= 1;
          m_busy  <= 1'b1;
        end
      end else if (m_phase == 1) begin
        if (oas == m_oreq) begin
          m_phase <= 2;
        end else begin
          if (m_wait < TOI) m_wait <= m_wait + 1;
          if (TOI > 0 && m_wait + 1 >= TOI) m_err <= 1'b1;
        end
      end else begin
        m_ack[m_gid] <= ~m_ack[m_gid];
        m_last       <= m_gid;
        m_phase      <= 0;
        m_busy       <= 1'b0;
      end
      rq_line[0] <= bus.req;
      oa_line[0] <= bus.out_ack;
      for (int k = 1; k < SS; k++) begin
        rq_line[k] <= rq_line[k-1];
        oa_line[k] <= oa_line[k-1];
      end
    end
  end

  // Per-cycle compare of every output against the model
  always @(negedge clk) begin
    if (!rst) begin
      check("cyc_ack",         32'(bus.ack),         32'(m_ack));
      check("cyc_out_req",     32'(bus.out_req),     32'(m_oreq));
      check("cyc_data_out",    32'(bus.data_out),    32'(m_data));
      check("cyc_grant_id",    32'(bus.grant_id),    32'(m_gid));
      check("cyc_busy",        32'(bus.busy),        32'(m_busy));
      check("cyc_timeout_err", 32'(bus.timeout_err), 32'(m_err));
    end
  end

  // Observed out_req toggles and the grant that went with each
  logic prev_oreq = 1'b0;
  int   n_toggles = 0;
  int   order_q[$];
  always @(negedge clk) begin
    if (bus.out_req !== prev_oreq) begin
      n_toggles <= n_toggles + 1;
      order_q.push_back(int'(bus.grant_id));
    end
    prev_oreq <= bus.out_req;
  end

  // Downstream channel that echoes out_req about two cycles later
  bit   echo_en = 1'b0;
  logic e1 = 1'b0, e2 = 1'b0;
  initial forever begin
    @(posedge clk);
    #2;
    if (echo_en) begin
      bus.out_ack = e2;
      e2 = e1;
      e1 = bus.out_req;
    end
  end

  // Hard stop if something hangs
  initial begin
    #100000;
    miscompares++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : stim
    int          base_t, base_o;
    int          exp_ord [4];
    logic [7:0]  words [3];
    exp_ord = '{0, 1, 0, 1};
    words   = '{8'h3C, 8'h5A, 8'hC3};

    bus.req = '0; bus.data_in = '0; bus.out_ack = 1'b0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_ack",      32'(bus.ack),         32'h0);
    check("rst_out_req",  32'(bus.out_req),     32'h0);
    check("rst_busy",     32'(bus.busy),        32'h0);
    check("rst_grant_id", 32'(bus.grant_id),    32'h0);
    check("rst_err",      32'(bus.timeout_err), 32'h0);
    check("rst_data_out", 32'(bus.data_out),    32'h0);

    // Single request: grant 3 cycles after req, ack 4 cycles after out_ack
    bus.data_in[7:0] = 8'hA5;
    bus.req[0] = 1'b1;
    tick(3);
    check("single_out_req",   32'(bus.out_req),  32'h1);
    check("single_grant",     32'(bus.grant_id), 32'h0);
    check("single_data",      32'(bus.data_out), 32'hA5);
    check("single_busy",      32'(bus.busy),     32'h1);
    check("model_out_req_c3", 32'(m_oreq),       32'h1);
    tick(2);
    bus.out_ack = 1'b1;
    tick(3);
    check("single_ack_c8",  32'(bus.ack),  32'h0);
    check("single_busy_c8", 32'(bus.busy), 32'h1);
    tick(1);
    check("single_ack_c9",  32'(bus.ack),  32'h1);
    check("single_busy_c9", 32'(bus.busy), 32'h0);
    check("model_ack_c9",   32'(m_ack),    32'h1);

    // Asynchronous reset with the clock parked
    clk_en = 1'b0;
    #20;
    rst = 1'b1;
    bus.req = '0;
    bus.out_ack = 1'b0;
    #1;
    check("async_rst_ack",      32'(bus.ack),         32'h0);
    check("async_rst_out_req",  32'(bus.out_req),     32'h0);
    check("async_rst_busy",     32'(bus.busy),        32'h0);
    check("async_rst_grant_id", 32'(bus.grant_id),    32'h0);
    check("async_rst_err",      32'(bus.timeout_err), 32'h0);
    #10;
    rst = 1'b0;
    #3;
    clk_en = 1'b1;
    tick(3);

    // Contention: two rounds of simultaneous toggles, expect 0,1,0,1
    base_t = n_toggles;
    base_o = order_q.size();
    bus.data_in = {8'h22, 8'h11};
    e1 = bus.out_req; e2 = bus.out_req;
    echo_en = 1'b1;
    bus.req = 2'b11;
    wait_ack(2'b11, 80, "contention_round1");
    bus.req = 2'b00;
    wait_ack(2'b00, 80, "contention_round2");
    tick(2);
    check("contention_toggles", 32'(n_toggles - base_t), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (order_q.size() > base_o + k) check("contention_order", 32'(order_q[base_o+k]), 32'(exp_ord[k]));
      else check("contention_order_missing", 32'(order_q.size() - base_o), 32'd4);
    end

    // Back-to-back transfers from requester 1 with fresh words
    base_t = n_toggles;
    for (int k = 0; k < 3; k++) begin
      bus.data_in[15:8] = words[k];
      bus.req[1] = ~bus.req[1];
      tick(SS + 1);
      check("b2b_data",  32'(bus.data_out), 32'(words[k]));
      check("b2b_grant", 32'(bus.grant_id), 32'h1);
      wait_ack(bus.req, 40, "b2b_ack");
    end
    tick(2);
    check("b2b_toggles", 32'(n_toggles - base_t), 32'd3);
    check("b2b_ack_end", 32'(bus.ack), 32'h2);

    // Watchdog: channel silent, flag after 16 waiting cycles
    echo_en = 1'b0;
    bus.req[0] = 1'b1;
    tick(3);
    check("wd_busy_start", 32'(bus.busy), 32'h1);
    tick(15);
    check("wd_err_c18", 32'(bus.timeout_err), 32'h0);
    tick(1);
    check("wd_err_c19",  32'(bus.timeout_err), 32'h1);
    check("wd_busy_c19", 32'(bus.busy),        32'h1);
    tick(10);
    check("wd_busy_hold", 32'(bus.busy), 32'h1);
    bus.out_ack = ~bus.out_ack;
    wait_ack(2'b11, 20, "wd_late_ack");
    check("wd_err_sticky", 32'(bus.timeout_err), 32'h1);

    // Reset in the middle of a transfer, then re-service of req[0]
    bus.req[1] = 1'b0;
    tick(5);
    check("midrst_busy_before", 32'(bus.busy), 32'h1);
    rst = 1'b1;
    bus.out_ack = 1'b0;
    #1;
    check("midrst_ack",      32'(bus.ack),         32'h0);
    check("midrst_out_req",  32'(bus.out_req),     32'h0);
    check("midrst_busy",     32'(bus.busy),        32'h0);
    check("midrst_grant_id", 32'(bus.grant_id),    32'h0);
    check("midrst_err",      32'(bus.timeout_err), 32'h0);
    check("midrst_data",     32'(bus.data_out),    32'h0);
    tick(2);
    rst = 1'b0;
    tick(SS);
    check("midrst_out_req_early", 32'(bus.out_req), 32'h0);
    tick(1);
    check("midrst_out_req_regrant", 32'(bus.out_req),  32'h1);
    check("midrst_grant_regrant",   32'(bus.grant_id), 32'h0);
    check("midrst_busy_regrant",    32'(bus.busy),     32'h1);
    e1 = 1'b0; e2 = 1'b0;
    echo_en = 1'b1;
    wait_ack(2'b01, 30, "midrst_complete");
    check("midrst_err_after", 32'(bus.timeout_err), 32'h0);

    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
